// File: rtl/ondra_par_responder.sv
// Ondra parallel-port responder: strobe filter, Centronics BUSY/nACK handshake and FWFT byte FIFO.
// Optional statistics counters are enabled with `define ONDRA_PAR_STATS_EN.
module ondra_par_responder #(
    parameter int DEPTH_LOG2     = 4,
    parameter int MIN_STB_CYCLES = 4,
    parameter int ACK_CYCLES     = 40
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  non_stb_i,
    input  logic [7:0]            pdata_i,
    output logic                  busy_o,
    output logic                  non_ack_o,
    output logic [7:0]            m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    input  logic                  clr_ovf_i
`ifdef ONDRA_PAR_STATS_EN
    ,
    output logic [15:0]           rx_count_o,
    output logic [15:0]           drop_count_o
`endif
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_MAX = (ACK_CYCLES > MIN_STB_CYCLES) ? ACK_CYCLES : MIN_STB_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FILTER, CAPTURE, ACK, WAIT_HI} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [1:0]            rst_pipe;
    logic                  rst_int;
    logic                  stb_meta, stb_s;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level, level_n;
    logic                  full, pop, push, drop;

    // Reset asserts immediately but releases in step with clk_sys.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) rst_pipe <= 2'b11;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst_int = rst_pipe[1];

    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            stb_meta <= 1'b1;
            stb_s    <= 1'b1;
        end else begin
            stb_meta <= non_stb_i;
            stb_s    <= stb_meta;
        end
    end

    assign full      = (level == FULL_LEVEL);
    assign m_valid_o = (level != '0);
    assign pop       = m_valid_o & m_ready_i;
    assign m_data_o  = m_valid_o ? mem[rd_ptr] : 8'h00;
    assign level_o   = level;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        push    = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (!stb_s) begin
                    state_n = FILTER;
                    cnt_n   = CNT_W'(1);
                end
            end
            FILTER: begin
                if (stb_s)                               state_n = IDLE;
                else if (cnt == CNT_W'(MIN_STB_CYCLES)) state_n = CAPTURE;
                else                                     cnt_n   = cnt + 1'b1;
            end
            CAPTURE: begin
                if (!full || pop) push = 1'b1;
                else              drop = 1'b1;
                state_n = ACK;
                cnt_n   = '0;
            end
            ACK: begin
                if (cnt == CNT_W'(ACK_CYCLES - 1)) state_n = WAIT_HI;
                else                               cnt_n   = cnt + 1'b1;
            end
            WAIT_HI: begin
                if (stb_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        level_n = level;
        case ({push, pop})
            2'b10:   level_n = level + 1'b1;
            2'b01:   level_n = level - 1'b1;
            default: level_n = level;
        endcase
    end

    // BUSY and nACK are computed from next state so both leave a flop cleanly.
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            busy_o     <= 1'b0;
            non_ack_o  <= 1'b1;
            overflow_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            level     <= level_n;
            busy_o    <= (state_n inside {CAPTURE, ACK, WAIT_HI}) || (level_n == FULL_LEVEL);
            non_ack_o <= (state_n != ACK);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)           overflow_o <= 1'b1;
            else if (clr_ovf_i) overflow_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= pdata_i;
    end

`ifdef ONDRA_PAR_STATS_EN
    // Saturating counters; deliberately untouched by clr_ovf_i.
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            rx_count_o   <= '0;
            drop_count_o <= '0;
        end else begin
            if (push && rx_count_o != 16'hFFFF)   rx_count_o   <= rx_count_o + 1'b1;
            if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 1'b1;
        end
    end
`endif

endmodule
